// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - register map, frame type and sequencer states for the MAX7219 controller
// Imported by max7219_spi_tx and max7219_controller.
package max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  typedef struct packed {
    logic [3:0] pad;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

  // SEQ_DIM is only reachable when runtime dimming is built in.
  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_INIT    = 2'd1,
    SEQ_REFRESH = 2'd2,
    SEQ_DIM     = 2'd3
  } seq_state_e;

  function automatic frame_t mk_frame(input logic [3:0] addr, input logic [7:0] data);
    frame_t f;
    f.pad  = 4'h0;
    f.addr = addr;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/hexfont.sv
// rtl/hexfont.sv - hex nibble to 7-segment font, no-decode byte order (bit7 DP, bit6..0 A..G)
// Ports:
//   hex  in  SIZE      packed nibbles, nibble k at hex[4k+3:4k]
//   seg  out SIZE*2    packed glyph bytes, byte k at seg[8k+7:8k]
module hexfont #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0]   hex,
  output logic [SIZE*2-1:0] seg
);

  // Lowercase b, c and d keep them distinct from 8, 0/C and 0.
  function automatic logic [7:0] glyph(input logic [3:0] h);
    case (h)
      4'h0:    glyph = 8'h7E;
      4'h1:    glyph = 8'h30;
      4'h2:    glyph = 8'h6D;
      4'h3:    glyph = 8'h79;
      4'h4:    glyph = 8'h33;
      4'h5:    glyph = 8'h5B;
      4'h6:    glyph = 8'h5F;
      4'h7:    glyph = 8'h70;
      4'h8:    glyph = 8'h7F;
      4'h9:    glyph = 8'h7B;
      4'hA:    glyph = 8'h77;
      4'hB:    glyph = 8'h1F;
      4'hC:    glyph = 8'h0D;
      4'hD:    glyph = 8'h3D;
      4'hE:    glyph = 8'h4F;
      default: glyph = 8'h47;
    endcase
  endfunction

  for (genvar k = 0; k < SIZE / 4; k++) begin : g_digit
    assign seg[8*k +: 8] = glyph(hex[4*k +: 4]);
  end

endmodule

// File: rtl/max7219_spi_tx.sv
// rtl/max7219_spi_tx.sv - serializes one 16-bit frame onto DIN/CLK/LOAD including the LOAD gap
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start, frame        start is taken only while idle; frame is latched with it
//   done                one-cycle pulse on the last busy cycle of the frame
//   max_din/clk/load    registered serial pins
module max7219_spi_tx
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  frame_t frame,
  output logic   done,
  output logic   max_din,
  output logic   max_clk,
  output logic   max_load
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);
  // done fires two cycles before the gap ends: one cycle for the caller to
  // register start and one for this block to accept it, so LOAD falls again
  // exactly 2*CLK_DIV cycles after it rose.
  localparam logic [5:0] DONE_HALF = (CLK_DIV == 1) ? 6'd33 : 6'd34;
  localparam logic [7:0] DONE_CNT  = (CLK_DIV == 1) ? 8'd0 : 8'(CLK_DIV - 2);

  logic        active;
  logic [5:0]  half;     // half-period index: 0..31 bits, 32 tail, 33..34 gap
  logic [7:0]  cnt;
  logic [15:0] shreg;
  logic [5:0]  half_nx;

  assign half_nx = half + 6'd1;
  assign done    = active && (half == DONE_HALF) && (cnt == DONE_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      half     <= 6'd0;
      cnt      <= 8'd0;
      shreg    <= 16'h0;
      max_din  <= 1'b0;
      max_clk  <= 1'b0;
      max_load <= 1'b1;
    end else if (!active) begin
      if (start) begin
        active   <= 1'b1;
        half     <= 6'd0;
        cnt      <= 8'd0;
        shreg    <= {frame[14:0], 1'b0};
        max_din  <= frame[15];
        max_clk  <= 1'b0;
        max_load <= 1'b0;
      end
    end else if (done) begin
      active <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= 8'd0;
      half <= half_nx;
      if (half_nx < 6'd32) begin
        max_clk <= half_nx[0];
        if (!half_nx[0]) begin
          max_din <= shreg[15];
          shreg   <= {shreg[14:0], 1'b0};
        end
      end else if (half_nx == 6'd32) begin
        max_clk <= 1'b0;
      end else if (half_nx == 6'd33) begin
        max_load <= 1'b1;
      end
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/max7219_controller.sv
// rtl/max7219_controller.sv - MAX7219 init and digit-refresh sequencer
// Optional build macro: MAX7219_DIMMING_EN adds a runtime intensity input.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   value               DIGITS hex nibbles, nibble k shown on digit register k+1
//   update              single-cycle refresh request
//   intensity           (MAX7219_DIMMING_EN only) runtime intensity 0..15
//   busy, init_done     sequencer status
//   max_din/clk/load    serial link to the MAX7219
module max7219_controller
  import max7219_pkg::*;
#(
  parameter int         CLK_DIV   = 2,
  parameter int         DIGITS    = 8,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGITS*4-1:0] value,
  input  logic                update,
`ifdef MAX7219_DIMMING_EN
  input  logic [3:0]          intensity,
`endif
  output logic                busy,
  output logic                init_done,
  output logic                max_din,
  output logic                max_clk,
  output logic                max_load
);

  localparam logic [1:0] S_IDLE    = SEQ_IDLE;
  localparam logic [1:0] S_INIT    = SEQ_INIT;
  localparam logic [1:0] S_REFRESH = SEQ_REFRESH;
  localparam logic [1:0] S_DIM     = SEQ_DIM;

  localparam logic [3:0] LAST_DIGIT = 4'(DIGITS - 1);
  localparam logic [3:0] LAST_INIT  = 4'd4;

  logic [1:0]          state;
  logic [3:0]          idx;
  logic                start;
  logic                pending;
  logic [DIGITS*4-1:0] snapshot;
  logic [DIGITS*8-1:0] seg;
  logic [7:0]          digit_seg;
  logic [3:0]          int_val;
  logic                tx_done;
  frame_t              tx_frame;
  logic                rerun;

  assign busy      = (state != S_IDLE);
  assign rerun     = pending | update;
  assign digit_seg = seg[8*idx +: 8];

`ifndef MAX7219_DIMMING_EN
  assign int_val = INTENSITY;
`endif

  hexfont #(.SIZE(DIGITS * 4)) u_font (
    .hex (snapshot),
    .seg (seg)
  );

  // Frame content follows the state/index registers, so it is valid in the
  // cycle start is high, including right after a snapshot capture.
  always_comb begin
    tx_frame = '0;
    case (state)
      S_INIT: begin
        case (idx)
          4'd0:    tx_frame = mk_frame(REG_TEST, 8'h00);
          4'd1:    tx_frame = mk_frame(REG_DECODE, 8'h00);
          4'd2:    tx_frame = mk_frame(REG_SCANLIM, {4'h0, LAST_DIGIT});
          4'd3:    tx_frame = mk_frame(REG_INTENSITY, {4'h0, int_val});
          default: tx_frame = mk_frame(REG_SHUTDOWN, 8'h01);
        endcase
      end
      S_REFRESH: tx_frame = mk_frame(REG_DIGIT0 + idx, digit_seg);
      S_DIM:     tx_frame = mk_frame(REG_INTENSITY, {4'h0, int_val});
      default:   tx_frame = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      start     <= 1'b0;
      init_done <= 1'b0;
      pending   <= 1'b0;
      snapshot  <= '0;
`ifdef MAX7219_DIMMING_EN
      int_val   <= 4'h0;
`endif
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!init_done) begin
            state <= S_INIT;
            idx   <= 4'd0;
            start <= 1'b1;
`ifdef MAX7219_DIMMING_EN
            int_val <= intensity;
`endif
          end
`ifdef MAX7219_DIMMING_EN
          else if (intensity != int_val) begin
            // Intensity goes out first; a coinciding update waits behind it.
            state   <= S_DIM;
            int_val <= intensity;
            start   <= 1'b1;
            if (update) pending <= 1'b1;
          end
`endif
          else if (update) begin
            state    <= S_REFRESH;
            snapshot <= value;
            idx      <= 4'd0;
            start    <= 1'b1;
          end
        end
        S_INIT: begin
          if (update) pending <= 1'b1;
          if (tx_done) begin
            start <= 1'b1;
            if (idx == LAST_INIT) begin
              init_done <= 1'b1;
              state     <= S_REFRESH;
              snapshot  <= value;
              idx       <= 4'd0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_REFRESH: begin
          if (update) pending <= 1'b1;
          if (tx_done) begin
            if (idx != LAST_DIGIT) begin
              idx   <= idx + 4'd1;
              start <= 1'b1;
            end else if (rerun) begin
              pending  <= 1'b0;
              snapshot <= value;
              idx      <= 4'd0;
              start    <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          if (update) pending <= 1'b1;
          if (tx_done) begin
            if (rerun) begin
              pending  <= 1'b0;
              state    <= S_REFRESH;
              snapshot <= value;
              idx      <= 4'd0;
              start    <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  max7219_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .frame    (tx_frame),
    .done     (tx_done),
    .max_din  (max_din),
    .max_clk  (max_clk),
    .max_load (max_load)
  );

endmodule

// File: tb/tb_max7219_controller.sv
// tb/tb_max7219_controller.sv - self-checking bench for max7219_controller
`timescale 1ns/1ps
module tb_max7219_controller;

  localparam int T      = 2;
  localparam int DIGITS = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        update = 1'b0;
  logic [31:0] value  = 32'h0;
`ifdef MAX7219_DIMMING_EN
  logic [3:0]  intensity = 4'h8;
`endif
  logic        busy, init_done, max_din, max_clk, max_load;

  always #5 clk = ~clk;

  max7219_controller #(.CLK_DIV(T), .DIGITS(DIGITS), .INTENSITY(4'h8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .update    (update),
`ifdef MAX7219_DIMMING_EN
    .intensity (intensity),
`endif
    .busy      (busy),
    .init_done (init_done),
    .max_din   (max_din),
    .max_clk   (max_clk),
    .max_load  (max_load)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] expq [$];
  logic [7:0]  font [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                             8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h0D, 8'h3D, 8'h4F, 8'h47};
  logic [15:0] lit_abcd [8] = '{16'h013D, 16'h020D, 16'h031F, 16'h0477,
                                16'h0579, 16'h066D, 16'h0730, 16'h087E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected frames of one refresh: digit k+1 shows the glyph of nibble k.
  task automatic push_refresh(input logic [31:0] v);
    for (int k = 0; k < DIGITS; k++)
      expq.push_back({4'h0, 4'(k + 1), font[v[4*k +: 4]]});
  endtask

  task automatic push_init();
    expq.push_back(16'h0F00);
    expq.push_back(16'h0900);
    expq.push_back(16'h0B07);
    expq.push_back(16'h0A08);
    expq.push_back(16'h0C01);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((expq.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  // Pin decoder: rebuilds frames from DIN on CLK rising edges and measures timing.
  logic        p_load = 1'b1, p_clk = 1'b0, p_din = 1'b0;
  logic        in_frame = 1'b0, have_gap = 1'b0, gap_busy_low = 1'b0;
  logic [15:0] cap = 16'h0;
  int          low_len = 0, gap_len = 0, clk_run = 0, rises = 0, terr = 0, n_frames = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      have_gap = 1'b0;
    end else begin
      if (p_load && !max_load) begin
        if (have_gap) begin
          if (gap_busy_low) chk("gap_min", 32'(gap_len >= 2*T), 32'd1);
          else              chk("gap_len", gap_len, 2*T);
        end
        in_frame = 1'b1;
        have_gap = 1'b0;
        cap      = 16'h0;
        rises    = 0;
        low_len  = 0;
        clk_run  = 0;
        terr     = 0;
      end
      if (in_frame && !max_load) begin
        low_len++;
        if (max_clk != p_clk) begin
          if (clk_run != T) terr++;
          clk_run = 1;
        end else begin
          clk_run++;
        end
        if (!p_clk && max_clk) begin
          cap = {cap[14:0], max_din};
          rises++;
        end
        if (p_clk && max_clk && max_din != p_din) terr++;
      end
      if (in_frame && !p_load && max_load) begin
        in_frame = 1'b0;
        n_frames++;
        chk("load_low_len", low_len, 33*T);
        chk("bit_count", rises, 16);
        chk("clk_phase_errors", terr, 0);
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame: got 0x%h expected no frame at %0t", cap, $time);
        end else begin
          chk("frame", cap, expq.pop_front());
        end
        have_gap     = 1'b1;
        gap_len      = 0;
        gap_busy_low = 1'b0;
      end
      if (have_gap && max_load) begin
        gap_len++;
        if (!busy) gap_busy_low = 1'b1;
      end
    end
    p_load = max_load;
    p_clk  = max_clk;
    p_din  = max_din;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nf;

    // Reset values
    tick();
    rst_n = 1'b0;
    tick(3);
    chk("rst_load", max_load, 1);
    chk("rst_clk", max_clk, 0);
    chk("rst_din", max_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);

    // Power-up configuration followed by a refresh of value 0
    push_init();
    push_refresh(32'h0);
    rst_n = 1'b1;
    tick();
    chk("busy_after_release", busy, 1);
    chk("init_done_during_init", init_done, 0);
    wait_done("init_seq_done", 3000);
    chk("init_done_set", init_done, 1);
    chk("idle_busy", busy, 0);

    // Update from idle, hand-computed frames
    value = 32'h0123ABCD;
    foreach (lit_abcd[i]) expq.push_back(lit_abcd[i]);
    pulse_update();
    chk("busy_next_cycle", busy, 1);
    wait_done("refresh_abcd_done", 2000);
    chk("busy_after_abcd", busy, 0);

    // Several updates during a refresh collapse into one rerun with the new value
    value = 32'h11111111;
    push_refresh(value);
    pulse_update();
    tick(100);
    pulse_update();
    value = 32'hFFFFFFFF;
    tick(50);
    pulse_update();
    tick(50);
    pulse_update();
    push_refresh(32'hFFFFFFFF);
    wait_done("pending_rerun_done", 3000);
    nf = n_frames;
    tick(300);
    chk("no_extra_refresh", n_frames - nf, 0);
    chk("busy_after_rerun", busy, 0);

    // Reset during the 7th bit of a frame
    value = 32'h89ABCDEF;
    pulse_update();
    n = 0;
    while (!(in_frame && rises == 6 && !max_clk) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_bit7", 32'(n < 500), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_load", max_load, 1);
    chk("midrst_clk", max_clk, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_init_done", init_done, 0);
    expq.delete();
    tick(3);
    push_init();
    push_refresh(value);
    rst_n = 1'b1;
    tick();
    chk("busy_after_rerelease", busy, 1);
    wait_done("reinit_done", 3000);
    chk("reinit_init_done", init_done, 1);

`ifdef MAX7219_DIMMING_EN
    // Runtime intensity change while idle: one intensity frame, no digits
    intensity = 4'h3;
    expq.push_back(16'h0A03);
    nf = n_frames;
    wait_done("dim_done", 1000);
    tick(300);
    chk("dim_frame_count", n_frames - nf, 1);
    chk("dim_busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/max7219_controller.md
Name: max7219_controller

Overview:
- Sequences a MAX7219 8-digit 7-segment driver over its 3-wire serial link (DIN/CLK/LOAD).
- After reset it writes the configuration registers, then refreshes all digit registers whenever the host pulses update.
- Each hex nibble is converted to segment data through the hexfont combinational font; the font byte order (bit7 = DP, bit6..0 = A..G) matches MAX7219 no-decode mode.
- Sits between the system's value source and the display pins.

Parameters:
- CLK_DIV, 2: clk cycles per serial-clock half period; legal range 1..255.
- DIGITS, 8: number of digits driven; legal range 1..8. Sets the scan limit to DIGITS-1.
- INTENSITY, 4'h8: power-up intensity register value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  DIGITS*4  hex value to display; nibble k goes to digit register k+1
- update  in  1  single-cycle request to refresh the digits
- busy  out  1  high while any frame or sequence is in progress
- init_done  out  1  high once the configuration sequence has completed
- max_din  out  1  serial data, MSB first
- max_clk  out  1  serial clock; MAX7219 samples on the rising edge
- max_load  out  1  LOAD/CS; low during a frame, rising edge latches the frame

Behaviour:
- Reset (asynchronous, effective immediately, also mid-frame):
  - max_load=1, max_clk=0, max_din=0, busy=0, init_done=0.
  - Pending flag and snapshot register are cleared.
  - Any in-progress frame is abandoned.
- Sequencer FSM states: IDLE, INIT, REFRESH.
  - First clk edge after rst_n deasserts: IDLE -> INIT; busy=1 from that cycle.
- INIT sends 5 frames in this order:
  - 0x0F00 (display test off)
  - 0x0900 (no decode)
  - 0x0B00|(DIGITS-1) (scan limit)
  - 0x0A00|INTENSITY
  - 0x0C01 (normal operation)
- End of INIT: init_done=1 and stays set until reset. INIT then goes straight to REFRESH.
- REFRESH:
  - On entry, value is captured into a snapshot; all digits of one refresh come from the same snapshot.
  - Sends DIGITS frames, addresses 0x01..DIGITS in ascending order.
  - Frame data = hexfont(snapshot nibble addr-1).
  - Frame format is {4'h0, addr[3:0], data[7:0]}.
- After REFRESH:
  - pending set: clear pending and re-enter REFRESH.
  - pending clear: go to IDLE with busy=0.
- update handling:
  - In IDLE with init_done=1: go to REFRESH next cycle.
  - During INIT or REFRESH: set pending. Multiple updates collapse into a single rerun, which uses value as sampled at rerun entry.
- Frame timing, with T = CLK_DIV:
  - max_load falls at frame start.
  - For each of the 16 bits, MSB first: max_din is set at bit start, max_clk is low for T cycles, then high for T cycles.
  - After bit 0's high phase, max_clk goes low.
  - max_load rises T cycles later and is held high for 2T cycles (inter-frame gap) before the next frame starts.
  - Totals: max_load low 33T cycles; frame period 35T cycles.
  - max_din holds its value through each high phase.
- busy stays high across inter-frame gaps within a sequence.

Optional Feature:
- Macro: MAX7219_DIMMING_EN.
- Defined:
  - Adds input port intensity[3:0].
  - A change of intensity, relative to the last written value, sets an intensity-pending flag.
  - When the sequencer is next in IDLE, it sends one frame 0x0A00|intensity before any pending refresh.
  - INIT uses the intensity input instead of the INTENSITY parameter.
- Undefined: no port exists; the intensity register is written only during INIT with INTENSITY.

Decomposition:
- Package max7219_pkg holds:
  - register address constants: REG_DIGIT0=4'h1, REG_DECODE=4'h9, REG_INTENSITY=4'hA, REG_SCANLIM=4'hB, REG_SHUTDOWN=4'hC, REG_TEST=4'hF
  - typedef frame_t (16-bit packed struct: pad[3:0], addr[3:0], data[7:0])
  - the sequencer state enum
- Sub-module max7219_spi_tx:
  - Serializes one frame_t.
  - Interface: start/frame input, done pulse output; owns CLK_DIV timing and the LOAD gap.
  - start is accepted only when idle.
- hexfont is instantiated once with SIZE=DIGITS*4 on the snapshot.

Test Plan:
- Reset release, DIGITS=8, INTENSITY=8, value=0: decoded frames are 0x0F00, 0x0900, 0x0B07, 0x0A08, 0x0C01, then 0x017E..0x087E. After that, init_done=1 and busy=0.
- value=32'h0123ABCD, pulse update in IDLE: frames are 0x013D, 0x020D, 0x031F, 0x0477, 0x0579, 0x066D, 0x0730, 0x087E.
- CLK_DIV=2: max_clk period is 4 clk cycles; max_load low for 66 cycles and high for at least 4 between frames. Sampling max_din on max_clk rising edges reproduces each frame exactly.
- Three update pulses during a refresh, with value changed to 32'hFFFFFFFF after the first: exactly one extra refresh follows, all frames carry data 0x47, then busy falls.
- Assert rst_n low mid-frame, during the 7th bit:
  - Same cycle: max_load=1, max_clk=0, busy=0.
  - After release: INIT restarts from 0x0F00.
- With MAX7219_DIMMING_EN, change intensity from 8 to 4'h3 while idle: a single frame 0x0A03 is sent and no digit frames follow.
